// File: rtl/pmod_da4_pkg.sv
// Shared definitions for the PmodDA4 (AD5628) multi-channel driver.
// Holds the AD5628 command codes, the controller and SPI shifter state encodings,
// the init-phase encoding, the 32-bit frame field positions and a frame builder.
package pmod_da4_pkg;

   // AD5628 command nibble, frame bits [27:24]
   typedef enum logic [3:0] {
      CmdWriteN       = 4'b0000,
      CmdWriteNUpdAll = 4'b0010,
      CmdWriteUpdN    = 4'b0011,
      CmdPower        = 4'b0100,
      CmdReset        = 4'b0111,
      CmdSetupRef     = 4'b1000
   } cmd_e;

   // Top-level sequencing: WAIT gap, frame in flight, dropped-beat gap, IDLE
   typedef enum logic [1:0] {
      CtrlWait,
      CtrlSend,
      CtrlDrop,
      CtrlIdle
   } ctrl_state_e;

   // SPI shifter: LOAD, SHIFT and DONE of a single frame
   typedef enum logic [1:0] {
      TxIdle,
      TxLoad,
      TxShift,
      TxDone
   } tx_state_e;

   typedef enum logic [1:0] {
      PhReset,
      PhRef,
      PhPower
   } init_phase_e;

   localparam int unsigned FrameW  = 32;
   localparam int unsigned CmdLsb  = 24;
   localparam int unsigned AddrLsb = 20;
   localparam int unsigned DataLsb = 8;
   localparam int unsigned AuxLsb  = 0;

   // Bits [31:28] are always zero.
   function automatic logic [FrameW-1:0] build_frame(input cmd_e       cmd,
                                                      input logic [3:0]  addr,
                                                      input logic [11:0] data,
                                                      input logic [7:0]  aux);
      logic [FrameW-1:0] f;
      f = '0;
      f[CmdLsb +: 4]   = cmd;
      f[AddrLsb +: 4]  = addr;
      f[DataLsb +: 12] = data;
      f[AuxLsb +: 8]   = aux;
      return f;
   endfunction

endpackage

// File: rtl/pmod_da4_multi_if.sv
// AXI-Stream sample port of the PmodDA4 driver.
//   tdata  - sample, top 12 bits form the DAC code
//   tdest  - target DAC channel
//   tlast  - last sample of a set (simultaneous-update mode)
//   tvalid - sample valid (master)
//   tready - driver ready (slave)
interface pmod_da4_multi_if #(
   parameter int unsigned DATA_W = 14
) ();
   logic [DATA_W-1:0] tdata;
   logic [2:0]        tdest;
   logic              tlast;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, tdest, tlast, tvalid, input tready);
   modport slave  (input tdata, tdest, tlast, tvalid, output tready);
endinterface

// File: rtl/pmod_da4_spi_tx.sv
// 32-bit SPI frame shifter for the AD5628.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   frame_i           - frame to send, captured when start_i is seen while idle
//   start_i           - request a frame
//   busy_o            - frame in progress (LOAD/SHIFT/DONE)
//   done_o            - high in the last DONE cycle, i.e. the cycle the shifter goes idle
//   sck_o/sdi_o/sync_n_o - SPI pins, all registered
module pmod_da4_spi_tx
   import pmod_da4_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 25,
   parameter int unsigned SAMPLE_EDGE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [FrameW-1:0] frame_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              sck_o,
   output logic              sdi_o,
   output logic              sync_n_o
);

   localparam int unsigned      DivW   = $clog2(2 * CLK_DIV + 1);
   localparam logic [DivW-1:0]  RiseAt = DivW'(CLK_DIV - 1);
   localparam logic [DivW-1:0]  FallAt = DivW'(2 * CLK_DIV - 1);
   localparam logic [DivW-1:0]  DoneAt = DivW'(CLK_DIV);

   tx_state_e         state_q;
   logic [FrameW-1:0] shreg_q;
   logic [DivW-1:0]   div_q;
   logic [4:0]        bit_q;
   logic              sck_q;
   logic              sdi_q;
   logic              sync_n_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= TxIdle;
         shreg_q  <= '0;
         div_q    <= '0;
         bit_q    <= '0;
         sck_q    <= 1'b0;
         sdi_q    <= 1'b0;
         sync_n_q <= 1'b1;
      end else begin
         unique case (state_q)
            TxIdle: begin
               if (start_i) begin
                  shreg_q <= frame_i;
                  state_q <= TxLoad;
               end
            end
            TxLoad: begin
               sync_n_q <= 1'b0;
               sdi_q    <= shreg_q[FrameW-1];
               div_q    <= '0;
               bit_q    <= '0;
               state_q  <= TxShift;
            end
            TxShift: begin
               if (div_q == RiseAt) begin
                  sck_q <= 1'b1;
                  div_q <= div_q + 1'b1;
                  // Falling-edge sampling: bit 31 is already on sdi for the first edge.
                  if (SAMPLE_EDGE != 0 && bit_q != 5'd0) begin
                     sdi_q   <= shreg_q[FrameW-2];
                     shreg_q <= {shreg_q[FrameW-2:0], 1'b0};
                  end
               end else if (div_q == FallAt) begin
                  sck_q <= 1'b0;
                  div_q <= '0;
                  if (bit_q == 5'd31) begin
                     sync_n_q <= 1'b1;
                     state_q  <= TxDone;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                     if (SAMPLE_EDGE == 0) begin
                        sdi_q   <= shreg_q[FrameW-2];
                        shreg_q <= {shreg_q[FrameW-2:0], 1'b0};
                     end
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            default: begin
               // TxDone: CLK_DIV+1 cycles of sync_n high before the next frame
               if (div_q == DoneAt) begin
                  div_q   <= '0;
                  state_q <= TxIdle;
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
         endcase
      end
   end

   assign busy_o   = (state_q != TxIdle);
   assign done_o   = (state_q == TxDone) && (div_q == DoneAt);
   assign sck_o    = sck_q;
   assign sdi_o    = sdi_q;
   assign sync_n_o = sync_n_q;

endmodule

// File: rtl/pmod_da4_multi.sv
// Multi-channel PmodDA4 (AD5628) driver.
// Runs the DAC init sequence (reset, optional internal reference, channel power-up),
// then turns AXI-Stream samples into write frames addressed by tdest.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   s_axis     - sample stream (slave modport)
//   sck, sdi, sync_n - SPI pins to the Pmod connector
//   init_done  - high once channel power-up has been sent
//   err_addr   - one-cycle pulse when a beat with tdest >= NUM_CH is dropped
module pmod_da4_multi
   import pmod_da4_pkg::*;
#(
   parameter int unsigned CLK_DIV      = 25,
   parameter int unsigned WAIT_CYCLES  = 2500,
   parameter int unsigned DATA_W       = 14,
   parameter int unsigned NUM_CH       = 8,
   parameter int unsigned INT_REF      = 1,
   parameter int unsigned SIMUL_UPDATE = 0,
   parameter int unsigned SAMPLE_EDGE  = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   pmod_da4_multi_if.slave         s_axis,
   output logic                    sck,
   output logic                    sdi,
   output logic                    sync_n,
   output logic                    init_done,
   output logic                    err_addr
);

   localparam logic [7:0] ChMask = 8'((9'd1 << NUM_CH) - 9'd1);

   ctrl_state_e       state_q;
   init_phase_e       phase_q;
   logic [31:0]       wait_cnt_q;
   logic [FrameW-1:0] frame_q;
   logic              start_q;
   logic              tready_q;
   logic              init_done_q;
   logic              err_q;

   logic [FrameW-1:0] init_frame;
   logic [FrameW-1:0] smp_frame;
   cmd_e              smp_cmd;
   logic              addr_bad;
   logic              tx_busy;
   logic              tx_done;

   always_comb begin
      init_frame = '0;
      unique case (phase_q)
         PhReset: init_frame = build_frame(CmdReset, 4'hF, 12'h000, 8'h00);
         PhRef:   init_frame = build_frame(CmdSetupRef, 4'h0, 12'h000, 8'h01);
         default: init_frame = build_frame(CmdPower, 4'h0, 12'h000, ChMask);
      endcase

      smp_cmd = CmdWriteUpdN;
      if (SIMUL_UPDATE != 0) begin
         smp_cmd = s_axis.tlast ? CmdWriteNUpdAll : CmdWriteN;
      end
      // Upper 12 bits of the sample, truncated
      smp_frame = build_frame(smp_cmd, {1'b0, s_axis.tdest},
                              12'(s_axis.tdata >> (DATA_W - 12)), 8'h00);
      addr_bad  = ({29'd0, s_axis.tdest} >= NUM_CH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= CtrlWait;
         phase_q     <= PhReset;
         wait_cnt_q  <= '0;
         frame_q     <= '0;
         start_q     <= 1'b0;
         tready_q    <= 1'b0;
         init_done_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         err_q   <= 1'b0;
         start_q <= 1'b0;
         unique case (state_q)
            CtrlWait: begin
               if (wait_cnt_q == 32'(WAIT_CYCLES - 1)) begin
                  wait_cnt_q <= '0;
                  frame_q    <= init_frame;
                  start_q    <= 1'b1;
                  state_q    <= CtrlSend;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            CtrlSend: begin
               if (tx_done) begin
                  if (init_done_q) begin
                     tready_q <= 1'b1;
                     state_q  <= CtrlIdle;
                  end else begin
                     unique case (phase_q)
                        PhReset: begin
                           phase_q <= (INT_REF != 0) ? PhRef : PhPower;
                           state_q <= CtrlWait;
                        end
                        PhRef: begin
                           phase_q <= PhPower;
                           state_q <= CtrlWait;
                        end
                        default: begin
                           init_done_q <= 1'b1;
                           tready_q    <= 1'b1;
                           state_q     <= CtrlIdle;
                        end
                     endcase
                  end
               end
            end
            CtrlDrop: begin
               // One extra cycle so tready returns two cycles after a dropped beat
               state_q <= CtrlIdle;
            end
            default: begin
               if (s_axis.tvalid && tready_q) begin
                  tready_q <= 1'b0;
                  if (addr_bad) begin
                     err_q   <= 1'b1;
                     state_q <= CtrlDrop;
                  end else begin
                     frame_q <= smp_frame;
                     start_q <= 1'b1;
                     state_q <= CtrlSend;
                  end
               end else begin
                  tready_q <= !tx_busy;
               end
            end
         endcase
      end
   end

   pmod_da4_spi_tx #(
      .CLK_DIV     (CLK_DIV),
      .SAMPLE_EDGE (SAMPLE_EDGE)
   ) u_spi_tx (
      .clk      (clk),
      .rst_n    (rst_n),
      .frame_i  (frame_q),
      .start_i  (start_q),
      .busy_o   (tx_busy),
      .done_o   (tx_done),
      .sck_o    (sck),
      .sdi_o    (sdi),
      .sync_n_o (sync_n)
   );

   assign s_axis.tready = tready_q;
   assign init_done     = init_done_q;
   assign err_addr      = err_q;

endmodule

// File: tb/tb_pmod_da4_multi.sv
// Bench for pmod_da4_multi: four instances with different parameter sets, run one after
// another. A shared SPI monitor decodes each instance's frames from its pins.
//   0: defaults
//   1: NUM_CH=4, INT_REF=0, CLK_DIV=4, WAIT_CYCLES=20
//   2: SIMUL_UPDATE=1, CLK_DIV=4, WAIT_CYCLES=20
//   3: SAMPLE_EDGE=1, CLK_DIV=4, WAIT_CYCLES=20
module tb_pmod_da4_multi;

   logic       clk = 1'b0;
   logic [3:0] rst_n_v = 4'b0000;
   logic [3:0] sck_v, sdi_v, sync_v, done_v, err_v, rdy;

   logic        tv   [4] = '{default: 1'b0};
   logic        tl   [4] = '{default: 1'b0};
   logic [13:0] td   [4] = '{default: 14'h0};
   logic [2:0]  tdst [4] = '{default: 3'h0};

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pmod_da4_multi_if #(.DATA_W(14)) ax0 ();
   pmod_da4_multi_if #(.DATA_W(14)) ax1 ();
   pmod_da4_multi_if #(.DATA_W(14)) ax2 ();
   pmod_da4_multi_if #(.DATA_W(14)) ax3 ();

   assign ax0.tvalid = tv[0];  assign ax0.tlast = tl[0];
   assign ax0.tdata  = td[0];  assign ax0.tdest = tdst[0];
   assign ax1.tvalid = tv[1];  assign ax1.tlast = tl[1];
   assign ax1.tdata  = td[1];  assign ax1.tdest = tdst[1];
   assign ax2.tvalid = tv[2];  assign ax2.tlast = tl[2];
   assign ax2.tdata  = td[2];  assign ax2.tdest = tdst[2];
   assign ax3.tvalid = tv[3];  assign ax3.tlast = tl[3];
   assign ax3.tdata  = td[3];  assign ax3.tdest = tdst[3];
   assign rdy = {ax3.tready, ax2.tready, ax1.tready, ax0.tready};

   pmod_da4_multi u_dut0 (
      .clk(clk), .rst_n(rst_n_v[0]), .s_axis(ax0), .sck(sck_v[0]), .sdi(sdi_v[0]),
      .sync_n(sync_v[0]), .init_done(done_v[0]), .err_addr(err_v[0])
   );

   pmod_da4_multi #(.CLK_DIV(4), .WAIT_CYCLES(20), .NUM_CH(4), .INT_REF(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n_v[1]), .s_axis(ax1), .sck(sck_v[1]), .sdi(sdi_v[1]),
      .sync_n(sync_v[1]), .init_done(done_v[1]), .err_addr(err_v[1])
   );

   pmod_da4_multi #(.CLK_DIV(4), .WAIT_CYCLES(20), .SIMUL_UPDATE(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n_v[2]), .s_axis(ax2), .sck(sck_v[2]), .sdi(sdi_v[2]),
      .sync_n(sync_v[2]), .init_done(done_v[2]), .err_addr(err_v[2])
   );

   pmod_da4_multi #(.CLK_DIV(4), .WAIT_CYCLES(20), .SAMPLE_EDGE(1)) u_dut3 (
      .clk(clk), .rst_n(rst_n_v[3]), .s_axis(ax3), .sck(sck_v[3]), .sdi(sdi_v[3]),
      .sync_n(sync_v[3]), .init_done(done_v[3]), .err_addr(err_v[3])
   );

   // SPI monitor, sampled on the falling clk edge. Instance 3 is decoded on sck falling,
   // the others on sck rising. Only complete 32-bit frames are counted.
   logic [31:0] mon_sr     [4] = '{default: 32'h0};
   logic [31:0] frame_last [4] = '{default: 32'h0};
   logic        prev_sck   [4] = '{default: 1'b0};
   logic        prev_sdi   [4] = '{default: 1'b0};
   logic        prev_sync  [4] = '{default: 1'b1};
   int mon_bits  [4] = '{default: 0};
   int frame_cnt [4] = '{default: 0};
   int fall_cnt  [4] = '{default: 0};
   int gap_cnt   [4] = '{default: 0};
   int gap_at    [4] = '{default: 0};
   int rise_gap  [4] = '{default: 0};
   int sck_per   [4] = '{default: 0};
   int sdi_age   [4] = '{default: 100};
   int fall_age  [4] = '{default: 100};
   int viol = 0;
   int early_rdy = 0;

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         logic rise, fall, smp, chg;
         rise = sck_v[i] && !prev_sck[i];
         fall = !sck_v[i] && prev_sck[i];
         smp  = (i == 3) ? fall : rise;
         chg  = (sdi_v[i] != prev_sdi[i]);
         prev_sck[i]  <= sck_v[i];
         prev_sdi[i]  <= sdi_v[i];
         prev_sync[i] <= sync_v[i];
         if (!rst_n_v[i]) begin
            mon_bits[i] <= 0;
            gap_cnt[i]  <= 0;
         end else begin
            if (prev_sync[i] && !sync_v[i]) begin
               gap_at[i]   <= gap_cnt[i];
               gap_cnt[i]  <= 0;
               mon_bits[i] <= 0;
               fall_cnt[i] <= fall_cnt[i] + 1;
            end else begin
               if (sync_v[i]) gap_cnt[i] <= gap_cnt[i] + 1;
               if (smp) begin
                  mon_sr[i]   <= {mon_sr[i][30:0], sdi_v[i]};
                  mon_bits[i] <= mon_bits[i] + 1;
               end
               if (!prev_sync[i] && sync_v[i] && (mon_bits[i] + (smp ? 1 : 0)) == 32) begin
                  frame_last[i] <= smp ? {mon_sr[i][30:0], sdi_v[i]} : mon_sr[i];
                  frame_cnt[i]  <= frame_cnt[i] + 1;
               end
            end
            if (rise) begin
               sck_per[i]  <= rise_gap[i];
               rise_gap[i] <= 1;
            end else begin
               rise_gap[i] <= rise_gap[i] + 1;
            end
            // sdi must stay clear of the sampling (falling) sck edge by more than 1 clk
            if (i == 3 && (!sync_v[i] || !prev_sync[i])) begin
               if ((fall && (chg || sdi_age[i] == 0)) || (chg && fall_age[i] == 0))
                  viol <= viol + 1;
            end
            sdi_age[i]  <= chg  ? 0 : ((sdi_age[i] < 100)  ? sdi_age[i] + 1  : 100);
            fall_age[i] <= fall ? 0 : ((fall_age[i] < 100) ? fall_age[i] + 1 : 100);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n_v[1] && rdy[1] && !done_v[1]) early_rdy <= early_rdy + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wait_frame(input int i, input int old, input string tag);
      int n = 0;
      while (frame_cnt[i] == old && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check({tag, " count"}, 32'(frame_cnt[i] - old), 1);
   endtask

   task automatic send(input int i, input logic [13:0] data, input logic [2:0] dest,
                       input logic last);
      int n = 0;
      @(negedge clk);
      while (!rdy[i] && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("send ready", 32'(rdy[i]), 1);
      td[i]   = data;
      tdst[i] = dest;
      tl[i]   = last;
      tv[i]   = 1'b1;
      @(posedge clk);
      #1;
      tv[i] = 1'b0;
      tl[i] = 1'b0;
   endtask

   logic [31:0] exp_def [3] = '{32'h07F00000, 32'h08000001, 32'h040000FF};

   initial begin
      int c, t, f;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++)
         check("reset pins", 32'({sck_v[i], sdi_v[i], sync_v[i], rdy[i], done_v[i], err_v[i]}),
               32'b001000);

      // Instance 0: default init sequence
      rst_n_v[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         c = frame_cnt[0];
         wait_frame(0, c, "def init");
         check("def init frame", frame_last[0], exp_def[k]);
         check("def init gap>=2500", 32'(gap_at[0] >= 2500), 1);
         check("def init_done early", 32'(done_v[0]), 0);
      end
      repeat (30) @(negedge clk);
      check("def init_done", 32'(done_v[0]), 1);

      // Instance 0: one sample, latency to next tready and sck period
      c = frame_cnt[0];
      send(0, 14'h3FFC, 3'd3, 1'b0);
      t = 0;
      while (!rdy[0] && t < 3000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("def tready latency", 32'(t), 1628);
      check("def sample count", 32'(frame_cnt[0] - c), 1);
      check("def sample frame", frame_last[0], 32'h033FFF00);
      check("def sck period", 32'(sck_per[0]), 50);

      // Instance 1: tvalid held through init, no REF frame
      td[1] = 14'h0ABC; tdst[1] = 3'd1; tv[1] = 1'b1;
      rst_n_v[1] = 1'b1;
      c = frame_cnt[1];
      wait_frame(1, c, "ch4 init0");
      check("ch4 reset frame", frame_last[1], 32'h07F00000);
      c = frame_cnt[1];
      wait_frame(1, c, "ch4 init1");
      check("ch4 power frame", frame_last[1], 32'h0400000F);
      t = 0;
      while (!rdy[1] && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("ch4 ready after init", 32'(rdy[1]), 1);
      @(posedge clk);
      #1;
      tv[1] = 1'b0;
      c = frame_cnt[1];
      wait_frame(1, c, "ch4 sample");
      check("ch4 sample frame", frame_last[1], 32'h0312AF00);
      check("ch4 tready during init", 32'(early_rdy), 0);

      // Instance 1: out-of-range address is dropped
      f = fall_cnt[1];
      send(1, 14'h1111, 3'd5, 1'b0);
      check("bad addr err t+1", 32'({err_v[1], rdy[1]}), 32'b10);
      @(posedge clk);
      #1;
      check("bad addr err t+2", 32'({err_v[1], rdy[1]}), 32'b00);
      @(posedge clk);
      #1;
      check("bad addr ready t+3", 32'({err_v[1], rdy[1]}), 32'b01);
      repeat (40) @(negedge clk);
      check("bad addr no frame", 32'(fall_cnt[1] - f), 0);

      // Instance 1: reset in the middle of a frame
      send(1, 14'h3FFF, 3'd2, 1'b0);
      t = 0;
      while (sync_v[1] && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (40) @(negedge clk);
      check("mid-shift sync low", 32'(sync_v[1]), 0);
      rst_n_v[1] = 1'b0;
      #1;
      check("reset abort pins", 32'({sync_v[1], sck_v[1], rdy[1], done_v[1]}), 32'b1000);
      repeat (3) @(negedge clk);
      c = frame_cnt[1];
      rst_n_v[1] = 1'b1;
      wait_frame(1, c, "restart");
      check("restart frame", frame_last[1], 32'h07F00000);

      // Instance 2: simultaneous update
      rst_n_v[2] = 1'b1;
      t = 0;
      while (!done_v[2] && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check("simul init_done", 32'(done_v[2]), 1);
      c = frame_cnt[2];
      send(2, 14'h2000, 3'd0, 1'b0);
      wait_frame(2, c, "simul ch0");
      check("simul ch0 frame", frame_last[2], 32'h00080000);
      c = frame_cnt[2];
      send(2, 14'h1000, 3'd1, 1'b1);
      wait_frame(2, c, "simul ch1");
      check("simul ch1 frame", frame_last[2], 32'h02140000);

      // Instance 3: falling-edge sampling
      rst_n_v[3] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         c = frame_cnt[3];
         wait_frame(3, c, "edge1 init");
         check("edge1 init frame", frame_last[3], exp_def[k]);
      end
      c = frame_cnt[3];
      send(3, 14'h1234, 3'd7, 1'b0);
      wait_frame(3, c, "edge1 sample");
      check("edge1 sample frame", frame_last[3], 32'h03748D00);
      check("edge1 sdi near fall", 32'(viol), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
